// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared types, constants and level/one-hot helpers for the 8259A
// interrupt acknowledge sequencer.
package pic8259_pkg;

    localparam int NUM_IRQ = 8;
    localparam int LEVEL_W = 3;

    // Acknowledge sequence states; all four encodings are used.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2,
        ACK3 = 2'd3
    } ack_state_t;

    // OCW2 {R, SL, EOI} command codes.
    localparam logic [2:0] OCW2_NS_EOI  = 3'b001;
    localparam logic [2:0] OCW2_SP_EOI  = 3'b011;
    localparam logic [2:0] OCW2_ROT_NS  = 3'b101;
    localparam logic [2:0] OCW2_ROT_SP  = 3'b111;
    localparam logic [2:0] OCW2_SET_PRI = 3'b110;

    // Encode a one-hot vector to its level; the lowest set bit wins if
    // more than one bit is set, and an all-zero vector encodes as 0.
    function automatic logic [LEVEL_W-1:0] onehot_to_level(input logic [NUM_IRQ-1:0] onehot);
        logic [LEVEL_W-1:0] level;
        level = {LEVEL_W{1'b0}};
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                level = LEVEL_W'(i);
            end else begin
                level = level;
            end
        end
        return level;
    endfunction

    // Decode a level to its one-hot bit.
    function automatic logic [NUM_IRQ-1:0] level_to_onehot(input logic [LEVEL_W-1:0] level);
        return {{(NUM_IRQ - 1){1'b0}}, 1'b1} << level;
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// Signal bundle between the acknowledge sequencer and the rest of the PIC.
// The slave modport is the sequencer's view; master is the driver's view.
interface interrupt_ack_sequencer_if;
    import pic8259_pkg::*;

    logic                 interrupt_acknowledge_n;
    logic [NUM_IRQ-1:0]   interrupt_to_service;
    logic [NUM_IRQ-1:0]   highest_level_in_service;
    logic                 mode_8086;
    logic                 auto_eoi;
    logic                 rotate_on_aeoi;
    logic                 ocw2_valid;
    logic [2:0]           ocw2_command;
    logic [LEVEL_W-1:0]   ocw2_level;

    logic                 interrupt_out;
    logic [NUM_IRQ-1:0]   in_service_register;
    logic [LEVEL_W-1:0]   priority_rotate;
    logic                 freeze_request;
    logic                 vector_enable;
    logic [LEVEL_W-1:0]   ack_level;

    modport slave (
        input  interrupt_acknowledge_n, interrupt_to_service, highest_level_in_service,
               mode_8086, auto_eoi, rotate_on_aeoi, ocw2_valid, ocw2_command, ocw2_level,
        output interrupt_out, in_service_register, priority_rotate, freeze_request,
               vector_enable, ack_level
    );

    modport master (
        output interrupt_acknowledge_n, interrupt_to_service, highest_level_in_service,
               mode_8086, auto_eoi, rotate_on_aeoi, ocw2_valid, ocw2_command, ocw2_level,
        input  interrupt_out, in_service_register, priority_rotate, freeze_request,
               vector_enable, ack_level
    );

endinterface

// File: rtl/interrupt_ack_sequencer_inta_edge_detector.sv
// INTA# edge detector: keeps the previous INTA# sample and flags falling and
// rising edges combinationally so the FSM acts on them at the next clock edge.
module inta_edge_detector (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inta_n_i,
    output logic fall_o,
    output logic rise_o
);

    logic prev_q;

    // Previous INTA# sample; resets to the idle (high) pin level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= inta_n_i;
        end
    end

    assign fall_o = prev_q & ~inta_n_i;
    assign rise_o = ~prev_q & inta_n_i;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259A interrupt acknowledge sequencer: runs the 2-pulse (8086) or 3-pulse
// (8080/85) INTA# sequence, owns the in-service register and the priority
// rotation pointer, and applies EOI / rotate / set-priority commands.
module interrupt_ack_sequencer #(
    parameter int NUM_IRQ        = 8,
    parameter int SPURIOUS_LEVEL = 7
) (
    input  logic                       clock,
    input  logic                       reset,
    interrupt_ack_sequencer_if.slave   bus
);
    import pic8259_pkg::*;

    ack_state_t           state_q, state_d;
    logic                 inta_fall, inta_rise;
    logic                 seq_start, seq_end;

    logic [NUM_IRQ-1:0]   isr_q, isr_d;
    logic [LEVEL_W-1:0]   rotate_q, rotate_d;
    logic                 int_q, int_d;
    logic                 freeze_q, freeze_d;
    logic                 vec_en_q, vec_en_d;
    logic [LEVEL_W-1:0]   ack_level_q, ack_level_d;
    logic                 spurious_q, spurious_d;

    logic                 request_present;
    logic [LEVEL_W-1:0]   request_level;
    logic [NUM_IRQ-1:0]   set_mask, clear_mask;

    inta_edge_detector u_inta_edge (
        .clk_i    (clock),
        .rst_i    (reset),
        .inta_n_i (bus.interrupt_acknowledge_n),
        .fall_o   (inta_fall),
        .rise_o   (inta_rise)
    );

    assign request_present = |bus.interrupt_to_service;
    assign request_level   = onehot_to_level(bus.interrupt_to_service);

    // Acknowledge FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, sequence start/end events and next values of the pin outputs.
    always_comb begin
        state_d     = state_q;
        seq_start   = 1'b0;
        seq_end     = 1'b0;
        ack_level_d = ack_level_q;
        spurious_d  = spurious_q;
        case (state_q)
            IDLE: begin
                if (inta_fall) begin
                    state_d     = ACK1;
                    seq_start   = 1'b1;
                    ack_level_d = request_present ? request_level : LEVEL_W'(SPURIOUS_LEVEL);
                    spurious_d  = ~request_present;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK1: begin
                state_d = inta_fall ? ACK2 : ACK1;
            end
            ACK2: begin
                // Mode is re-read every cycle, so a mid-sequence change only
                // selects which edge ends or advances ACK2.
                if (bus.mode_8086) begin
                    seq_end = inta_rise;
                    state_d = inta_rise ? IDLE : ACK2;
                end else begin
                    state_d = inta_fall ? ACK3 : ACK2;
                end
            end
            ACK3: begin
                seq_end = inta_rise;
                state_d = inta_rise ? IDLE : ACK3;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Vector bytes are driven during ACK2/ACK3 pulses, and during the
        // first pulse only in 8080 mode.
        case (state_d)
            ACK1:       vec_en_d = ~bus.mode_8086 & ~bus.interrupt_acknowledge_n;
            ACK2, ACK3: vec_en_d = ~bus.interrupt_acknowledge_n;
            default:    vec_en_d = 1'b0;
        endcase

        freeze_d = (state_d != IDLE);
        int_d    = (state_d == IDLE) ? request_present : 1'b0;
    end

    // ISR and rotate next-state: clear masks are applied before set masks so
    // a simultaneous set wins; an OCW2 rotate overrides an AEOI rotate.
    always_comb begin
        set_mask   = {NUM_IRQ{1'b0}};
        clear_mask = {NUM_IRQ{1'b0}};
        rotate_d   = rotate_q;

        if (seq_start && request_present) begin
            set_mask = level_to_onehot(request_level);
        end else begin
            set_mask = {NUM_IRQ{1'b0}};
        end

        if (seq_end && bus.auto_eoi) begin
            clear_mask = spurious_q ? {NUM_IRQ{1'b0}} : level_to_onehot(ack_level_q);
            rotate_d   = bus.rotate_on_aeoi ? ack_level_q : rotate_q;
        end else begin
            clear_mask = {NUM_IRQ{1'b0}};
        end

        if (bus.ocw2_valid) begin
            case (bus.ocw2_command)
                OCW2_NS_EOI: begin
                    clear_mask = clear_mask | bus.highest_level_in_service;
                end
                OCW2_SP_EOI: begin
                    clear_mask = clear_mask | level_to_onehot(bus.ocw2_level);
                end
                OCW2_ROT_NS: begin
                    // With nothing in service the mask is zero and the
                    // pointer is left alone.
                    clear_mask = clear_mask | bus.highest_level_in_service;
                    rotate_d   = (|bus.highest_level_in_service)
                                 ? onehot_to_level(bus.highest_level_in_service) : rotate_d;
                end
                OCW2_ROT_SP: begin
                    clear_mask = clear_mask | level_to_onehot(bus.ocw2_level);
                    rotate_d   = bus.ocw2_level;
                end
                OCW2_SET_PRI: begin
                    rotate_d = bus.ocw2_level;
                end
                default: begin
                    rotate_d = rotate_d;
                end
            endcase
        end else begin
            rotate_d = rotate_d;
        end

        isr_d = (isr_q & ~clear_mask) | set_mask;
    end

    // ISR, rotate pointer, acknowledged level and pin output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            isr_q       <= {NUM_IRQ{1'b0}};
            rotate_q    <= 3'b111;
            int_q       <= 1'b0;
            freeze_q    <= 1'b0;
            vec_en_q    <= 1'b0;
            ack_level_q <= 3'd0;
            spurious_q  <= 1'b0;
        end else begin
            isr_q       <= isr_d;
            rotate_q    <= rotate_d;
            int_q       <= int_d;
            freeze_q    <= freeze_d;
            vec_en_q    <= vec_en_d;
            ack_level_q <= ack_level_d;
            spurious_q  <= spurious_d;
        end
    end

    assign bus.in_service_register = isr_q;
    assign bus.priority_rotate     = rotate_q;
    assign bus.interrupt_out       = int_q;
    assign bus.freeze_request      = freeze_q;
    assign bus.vector_enable       = vec_en_q;
    assign bus.ack_level           = ack_level_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Bench for interrupt_ack_sequencer. Each acknowledge sequence pushes its
// expected end state into a queue; a monitor pops and compares it when
// freeze_request falls, counting vector_enable pulses inside the sequence.
module tb_interrupt_ack_sequencer;

    typedef struct {
        logic [7:0] isr;
        logic [2:0] rot;
        logic [2:0] ack;
        int         ve_pulses;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    interrupt_ack_sequencer_if bus();

    interrupt_ack_sequencer #(
        .NUM_IRQ        (8),
        .SPURIOUS_LEVEL (7)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: compares the queued expectation at each sequence end.
    logic fz_prev;
    logic ve_prev;
    int   ve_cnt;
    exp_t e_mon;
    always @(negedge clk) begin
        if (rst) begin
            fz_prev = 1'b0;
            ve_prev = 1'b0;
            ve_cnt  = 0;
        end else begin
            if (bus.freeze_request && !fz_prev) ve_cnt = 0;
            if (bus.vector_enable && !ve_prev) ve_cnt++;
            if (!bus.freeze_request && fz_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL seq_unexpected: sequence ended with no expectation queued");
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("seq_isr", 32'(bus.in_service_register), 32'(e_mon.isr));
                    chk("seq_rotate", 32'(bus.priority_rotate), 32'(e_mon.rot));
                    chk("seq_ack_level", 32'(bus.ack_level), 32'(e_mon.ack));
                    chk("seq_vector_pulses", 32'(ve_cnt), 32'(e_mon.ve_pulses));
                end
            end
            fz_prev = bus.freeze_request;
            ve_prev = bus.vector_enable;
        end
    end

    task automatic pulse();
        @(posedge clk); #1 bus.interrupt_acknowledge_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.interrupt_acknowledge_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // First pulse with an OCW2 strobe in the same cycle as the INTA# fall.
    task automatic pulse_with_ocw2(input logic [2:0] cmd, input logic [2:0] lvl);
        @(posedge clk);
        #1 bus.interrupt_acknowledge_n = 1'b0;
        bus.ocw2_valid = 1'b1; bus.ocw2_command = cmd; bus.ocw2_level = lvl;
        @(posedge clk); #1 bus.ocw2_valid = 1'b0;
        @(posedge clk); #1 bus.interrupt_acknowledge_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic ocw2(input logic [2:0] cmd, input logic [2:0] lvl, input logic [7:0] hlis);
        @(posedge clk);
        #1 bus.ocw2_valid = 1'b1; bus.ocw2_command = cmd; bus.ocw2_level = lvl;
        bus.highest_level_in_service = hlis;
        @(posedge clk); #1 bus.ocw2_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_seq(input logic [7:0] irq, input logic m8086, input logic [7:0] e_isr,
                           input logic [2:0] e_rot, input logic [2:0] e_ack, input int e_ve);
        exp_t e;
        e.isr = e_isr; e.rot = e_rot; e.ack = e_ack; e.ve_pulses = e_ve;
        exp_q.push_back(e);
        bus.interrupt_to_service = irq;
        bus.mode_8086 = m8086;
        @(posedge clk);
        pulse();
        bus.interrupt_to_service = 8'h00;
        pulse();
        if (!m8086) pulse();
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_isr"},    32'(bus.in_service_register), 32'h00);
        chk({tag, "_rotate"}, 32'(bus.priority_rotate), 32'h7);
        chk({tag, "_int"},    32'(bus.interrupt_out), 32'h0);
        chk({tag, "_freeze"}, 32'(bus.freeze_request), 32'h0);
        chk({tag, "_vec_en"}, 32'(bus.vector_enable), 32'h0);
        chk({tag, "_ack"},    32'(bus.ack_level), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.interrupt_acknowledge_n  = 1'b1;
        bus.interrupt_to_service     = 8'h00;
        bus.highest_level_in_service = 8'h00;
        bus.mode_8086      = 1'b1;
        bus.auto_eoi       = 1'b0;
        bus.rotate_on_aeoi = 1'b0;
        bus.ocw2_valid     = 1'b0;
        bus.ocw2_command   = 3'b000;
        bus.ocw2_level     = 3'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_values("reset");
        @(posedge clk); #1 rst = 1'b0;

        // IR3, 8086 mode, with INT and mid-sequence observation.
        bus.interrupt_to_service = 8'h08;
        bus.mode_8086 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t1_int_asserted", 32'(bus.interrupt_out), 32'h1);
        e.isr = 8'h08; e.rot = 3'd7; e.ack = 3'd3; e.ve_pulses = 1;
        exp_q.push_back(e);
        pulse();
        @(negedge clk);
        chk("t1_int_after_fall", 32'(bus.interrupt_out), 32'h0);
        chk("t1_ack_level_mid", 32'(bus.ack_level), 32'h3);
        chk("t1_freeze_mid", 32'(bus.freeze_request), 32'h1);
        chk("t1_isr_mid", 32'(bus.in_service_register), 32'h08);
        chk("t1_vec_en_pulse1", 32'(bus.vector_enable), 32'h0);
        bus.interrupt_to_service = 8'h00;
        pulse();
        repeat (2) @(posedge clk);
        ocw2(3'b011, 3'd3, 8'h00);
        chk("t1_specific_eoi", 32'(bus.in_service_register), 32'h00);

        // IR5, 8080 mode, three pulses; then non-specific EOI.
        run_seq(8'h20, 1'b0, 8'h20, 3'd7, 3'd5, 3);
        ocw2(3'b001, 3'd0, 8'h20);
        chk("t2_ns_eoi", 32'(bus.in_service_register), 32'h00);

        // AEOI with rotate, IR2, 8086 mode.
        bus.auto_eoi = 1'b1;
        bus.rotate_on_aeoi = 1'b1;
        run_seq(8'h04, 1'b1, 8'h00, 3'd2, 3'd2, 1);
        bus.auto_eoi = 1'b0;
        bus.rotate_on_aeoi = 1'b0;

        // Spurious acknowledge.
        run_seq(8'h00, 1'b1, 8'h00, 3'd2, 3'd7, 1);

        // Build ISR = 0A, then rotate non-specific on IR1.
        run_seq(8'h02, 1'b1, 8'h02, 3'd2, 3'd1, 1);
        run_seq(8'h08, 1'b1, 8'h0A, 3'd2, 3'd3, 1);
        ocw2(3'b101, 3'd0, 8'h02);
        chk("t5_rot_ns_isr", 32'(bus.in_service_register), 32'h08);
        chk("t5_rot_ns_rotate", 32'(bus.priority_rotate), 32'h1);

        // Specific EOI on level 3 colliding with the IR3 acknowledge.
        ocw2(3'b011, 3'd3, 8'h00);
        chk("t6_clear_before", 32'(bus.in_service_register), 32'h00);
        e.isr = 8'h08; e.rot = 3'd1; e.ack = 3'd3; e.ve_pulses = 1;
        exp_q.push_back(e);
        bus.interrupt_to_service = 8'h08;
        bus.mode_8086 = 1'b1;
        @(posedge clk);
        pulse_with_ocw2(3'b011, 3'd3);
        bus.interrupt_to_service = 8'h00;
        pulse();
        repeat (2) @(posedge clk);
        ocw2(3'b110, 3'd4, 8'h00);
        chk("t6_set_pri_rotate", 32'(bus.priority_rotate), 32'h4);
        chk("t6_set_pri_isr", 32'(bus.in_service_register), 32'h08);

        // Reset asserted while in ACK2 (second INTA# held low).
        bus.interrupt_to_service = 8'h10;
        bus.mode_8086 = 1'b1;
        @(posedge clk);
        pulse();
        bus.interrupt_to_service = 8'h00;
        @(posedge clk); #1 bus.interrupt_acknowledge_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t7_vec_en_in_ack2", 32'(bus.vector_enable), 32'h1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_reset_values("t7_async_reset");
        bus.interrupt_acknowledge_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        run_seq(8'h40, 1'b1, 8'h40, 3'd7, 3'd6, 1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
